// File: rtl/serial_bridge.sv
// serial_bridge: device-side endpoint of the processor byte-serial port.
// Two FWFT byte FIFOs: RX (host -> cpu) and TX (cpu -> host).
// Ports:
//   clock, reset (sync, active-high)
//   cpu_rx_data/cpu_rx_valid/cpu_rden      : core read side of RX FIFO
//   cpu_tx_data/cpu_wren/cpu_tx_ready      : core write side of TX FIFO
//   host_rx_data/host_rx_valid/host_rx_ready : host push into RX FIFO
//   host_tx_data/host_tx_valid/host_tx_ready : host pop from TX FIFO
// Optional macro SERIAL_BRIDGE_STATS_EN adds saturating counters
//   tx_drop_count (writes while full) and rx_underrun_count (reads while empty).

module serial_bridge_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       not_empty,
    output logic       not_full
);

    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign not_empty = (count != '0);
    assign not_full  = (count != FULL);
    // Ready/valid come from the count at the start of the cycle, so a
    // full FIFO never takes a push in the same cycle it is popped.
    assign push_ok   = push && not_full;
    assign pop_ok    = pop && not_empty;
    // Stale array contents are hidden while empty.
    assign rdata     = not_empty ? mem[rptr] : 8'h00;

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop_ok)
                rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push_ok)
            mem[wptr] <= wdata;
    end

endmodule

module serial_bridge #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] cpu_rx_data,
    output logic       cpu_rx_valid,
    input  logic       cpu_rden,
    input  logic [7:0] cpu_tx_data,
    input  logic       cpu_wren,
    output logic       cpu_tx_ready,
    input  logic [7:0] host_rx_data,
    input  logic       host_rx_valid,
    output logic       host_rx_ready,
    output logic [7:0] host_tx_data,
    output logic       host_tx_valid,
`ifdef SERIAL_BRIDGE_STATS_EN
    input  logic       host_tx_ready,
    output logic [7:0] tx_drop_count,
    output logic [7:0] rx_underrun_count
`else
    input  logic       host_tx_ready
`endif
);

    serial_bridge_fifo #(.DEPTH(DEPTH), .AW(AW)) rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (host_rx_valid),
        .wdata     (host_rx_data),
        .pop       (cpu_rden),
        .rdata     (cpu_rx_data),
        .not_empty (cpu_rx_valid),
        .not_full  (host_rx_ready)
    );

    serial_bridge_fifo #(.DEPTH(DEPTH), .AW(AW)) tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (cpu_wren),
        .wdata     (cpu_tx_data),
        .pop       (host_tx_ready),
        .rdata     (host_tx_data),
        .not_empty (host_tx_valid),
        .not_full  (cpu_tx_ready)
    );

`ifdef SERIAL_BRIDGE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_drop_count     <= 8'h00;
            rx_underrun_count <= 8'h00;
        end else begin
            if (cpu_wren && !cpu_tx_ready && tx_drop_count != 8'hFF)
                tx_drop_count <= tx_drop_count + 8'h01;
            if (cpu_rden && !cpu_rx_valid && rx_underrun_count != 8'hFF)
                rx_underrun_count <= rx_underrun_count + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_serial_bridge.sv
// tb_serial_bridge: directed self-checking bench for serial_bridge.
// Drives and samples 1ns after each rising edge.

module tb_serial_bridge;

    logic       clock;
    logic       reset;
    logic [7:0] cpu_rx_data;
    logic       cpu_rx_valid;
    logic       cpu_rden;
    logic [7:0] cpu_tx_data;
    logic       cpu_wren;
    logic       cpu_tx_ready;
    logic [7:0] host_rx_data;
    logic       host_rx_valid;
    logic       host_rx_ready;
    logic [7:0] host_tx_data;
    logic       host_tx_valid;
    logic       host_tx_ready;
`ifdef SERIAL_BRIDGE_STATS_EN
    logic [7:0] tx_drop_count;
    logic [7:0] rx_underrun_count;
`endif

    int errors = 0;
    int checks = 0;

    serial_bridge dut (
        .clock             (clock),
        .reset             (reset),
        .cpu_rx_data       (cpu_rx_data),
        .cpu_rx_valid      (cpu_rx_valid),
        .cpu_rden          (cpu_rden),
        .cpu_tx_data       (cpu_tx_data),
        .cpu_wren          (cpu_wren),
        .cpu_tx_ready      (cpu_tx_ready),
        .host_rx_data      (host_rx_data),
        .host_rx_valid     (host_rx_valid),
        .host_rx_ready     (host_rx_ready),
        .host_tx_data      (host_tx_data),
        .host_tx_valid     (host_tx_valid),
`ifdef SERIAL_BRIDGE_STATS_EN
        .host_tx_ready     (host_tx_ready),
        .tx_drop_count     (tx_drop_count),
        .rx_underrun_count (rx_underrun_count)
`else
        .host_tx_ready     (host_tx_ready)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs,
                       input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rxv"}, {8'h0, cpu_rx_valid}, 9'h0);
        chk({tag, "_txv"}, {8'h0, host_tx_valid}, 9'h0);
        chk({tag, "_rxr"}, {8'h0, host_rx_ready}, 9'h1);
        chk({tag, "_txr"}, {8'h0, cpu_tx_ready}, 9'h1);
        chk({tag, "_rxd"}, {1'b0, cpu_rx_data}, 9'h0);
        chk({tag, "_txd"}, {1'b0, host_tx_data}, 9'h0);
    endtask

    initial begin
        logic [7:0] b;
        reset         = 1'b1;
        cpu_rden      = 1'b0;
        cpu_wren      = 1'b0;
        cpu_tx_data   = 8'h00;
        host_rx_data  = 8'h00;
        host_rx_valid = 1'b0;
        host_tx_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk_idle("reset");
`ifdef SERIAL_BRIDGE_STATS_EN
        chk("rst_drop", {1'b0, tx_drop_count}, 9'h0);
        chk("rst_under", {1'b0, rx_underrun_count}, 9'h0);
`endif

        // RX ordering and full
        host_rx_valid = 1'b1;
        host_rx_data  = 8'hA1;
        step();
        chk("rx_lat_v", {8'h0, cpu_rx_valid}, 9'h1);
        chk("rx_lat_d", {1'b0, cpu_rx_data}, 9'hA1);
        host_rx_data = 8'hA2;
        step();
        host_rx_data = 8'hA3;
        step();
        host_rx_data = 8'hA4;
        step();
        host_rx_valid = 1'b0;
        chk("rx_full", {8'h0, host_rx_ready}, 9'h0);
        // offer A5 while full: must be refused
        host_rx_valid = 1'b1;
        host_rx_data  = 8'hA5;
        step();
        host_rx_valid = 1'b0;
        cpu_rden = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = 8'hA1 + 8'(i);
            chk("rx_order", {1'b0, cpu_rx_data}, {1'b0, b});
            step();
        end
        cpu_rden = 1'b0;
        chk("rx_empty_v", {8'h0, cpu_rx_valid}, 9'h0);
        chk("rx_empty_d", {1'b0, cpu_rx_data}, 9'h0);
        host_rx_valid = 1'b1;
        host_rx_data  = 8'hA5;
        step();
        host_rx_valid = 1'b0;
        chk("rx_a5", {1'b0, cpu_rx_data}, 9'hA5);
        cpu_rden = 1'b1;
        step();
        cpu_rden = 1'b0;
        chk("rx_a5_pop", {8'h0, cpu_rx_valid}, 9'h0);

        // TX full and drop
        host_tx_ready = 1'b0;
        cpu_wren = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_tx_data = 8'h10 + 8'(i);
            step();
        end
        chk("tx_full", {8'h0, cpu_tx_ready}, 9'h0);
        chk("tx_head", {1'b0, host_tx_data}, 9'h10);
        cpu_tx_data = 8'h14;
        step();
        cpu_wren = 1'b0;
`ifdef SERIAL_BRIDGE_STATS_EN
        chk("tx_drop", {1'b0, tx_drop_count}, 9'h1);
`endif
        host_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = 8'h10 + 8'(i);
            chk("tx_v", {8'h0, host_tx_valid}, 9'h1);
            chk("tx_order", {1'b0, host_tx_data}, {1'b0, b});
            step();
        end
        host_tx_ready = 1'b0;
        chk("tx_empty_v", {8'h0, host_tx_valid}, 9'h0);
        chk("tx_empty_d", {1'b0, host_tx_data}, 9'h0);

        // Simultaneous push/pop at occupancy 2
        host_rx_valid = 1'b1;
        host_rx_data  = 8'hB0;
        step();
        host_rx_data = 8'hB1;
        step();
        cpu_rden = 1'b1;
        for (int i = 0; i < 20; i++) begin
            host_rx_data = 8'hB2 + 8'(i);
            b = 8'hB0 + 8'(i);
            chk("pp_data", {1'b0, cpu_rx_data}, {1'b0, b});
            chk("pp_rdy", {8'h0, host_rx_ready}, 9'h1);
            step();
        end
        host_rx_valid = 1'b0;
        // occupancy still 2: exactly two more bytes then empty
        chk("pp_tail0", {1'b0, cpu_rx_data}, 9'hC4);
        step();
        chk("pp_tail1", {1'b0, cpu_rx_data}, 9'hC5);
        step();
        cpu_rden = 1'b0;
        chk("pp_empty", {8'h0, cpu_rx_valid}, 9'h0);

        // Underrun
        cpu_rden = 1'b1;
        step();
        step();
        step();
        cpu_rden = 1'b0;
        chk_idle("under");
`ifdef SERIAL_BRIDGE_STATS_EN
        chk("under_cnt", {1'b0, rx_underrun_count}, 9'h3);
        cpu_rden = 1'b1;
        for (int i = 0; i < 300; i++)
            step();
        cpu_rden = 1'b0;
        chk("under_sat", {1'b0, rx_underrun_count}, 9'hFF);
`endif

        // Reset mid-operation
        host_tx_ready = 1'b0;
        host_rx_valid = 1'b1;
        cpu_wren      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_rx_data = 8'hC1 + 8'(i);
            cpu_tx_data  = 8'hD1 + 8'(i);
            step();
        end
        chk("mid_rx", {1'b0, cpu_rx_data}, 9'hC1);
        chk("mid_tx", {1'b0, host_tx_data}, 9'hD1);
        host_rx_data  = 8'hEE;
        cpu_tx_data   = 8'hEE;
        host_tx_ready = 1'b1;
        cpu_rden      = 1'b1;
        reset = 1'b1;
        step();
        reset         = 1'b0;
        host_rx_valid = 1'b0;
        cpu_wren      = 1'b0;
        cpu_rden      = 1'b0;
        host_tx_ready = 1'b0;
        chk_idle("mrst");
`ifdef SERIAL_BRIDGE_STATS_EN
        chk("mrst_under", {1'b0, rx_underrun_count}, 9'h0);
        chk("mrst_drop", {1'b0, tx_drop_count}, 9'h0);
`endif
        host_rx_valid = 1'b1;
        host_rx_data  = 8'h55;
        cpu_wren      = 1'b1;
        cpu_tx_data   = 8'h66;
        step();
        host_rx_valid = 1'b0;
        cpu_wren      = 1'b0;
        chk("post_rx", {1'b0, cpu_rx_data}, 9'h55);
        chk("post_tx", {1'b0, host_tx_data}, 9'h66);
        cpu_rden      = 1'b1;
        host_tx_ready = 1'b1;
        step();
        cpu_rden      = 1'b0;
        host_tx_ready = 1'b0;
        chk_idle("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_bridge.md
# serial_bridge

Device-side endpoint of the processor's byte-serial port. It presents received bytes to the core through the `serial_in`/`serial_valid_in`/`serial_rden_out` read handshake. It accepts bytes written by the core through `serial_out`/`serial_wren_out`/`serial_ready_in`. Two small FIFOs decouple the core from an external byte stream that uses valid/ready handshakes on the host side. The block is instantiated beside `processor` at the top level, and its `cpu_*` ports wire directly to the processor's serial ports.

## Interface
- `DEPTH`, 4: entries per FIFO; a power of 2, ≥2.
- `AW`, $clog2(DEPTH): pointer width; derived, do not override.

- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `cpu_rx_data`  out  8: byte at the RX FIFO head; drives processor `serial_in`.
- `cpu_rx_valid`  out  1: RX FIFO non-empty; drives `serial_valid_in`.
- `cpu_rden`  in  1: pops the RX head; from `serial_rden_out`.
- `cpu_tx_data`  in  8: byte to send; from `serial_out`.
- `cpu_wren`  in  1: pushes `cpu_tx_data`; from `serial_wren_out`.
- `cpu_tx_ready`  out  1: TX FIFO not full; drives `serial_ready_in`.
- `host_rx_data`  in  8: incoming byte from the external stream.
- `host_rx_valid`  in  1: `host_rx_data` is valid.
- `host_rx_ready`  out  1: RX FIFO not full.
- `host_tx_data`  out  8: byte at the TX FIFO head.
- `host_tx_valid`  out  1: TX FIFO non-empty.
- `host_tx_ready`  in  1: external sink accepts `host_tx_data`.

## Operation
- RX path (host → core):
  - Push when `host_rx_valid && host_rx_ready`.
  - Pop when `cpu_rden && cpu_rx_valid`.
- TX path (core → host):
  - Push when `cpu_wren && cpu_tx_ready`.
  - Pop when `host_tx_valid && host_tx_ready`.
- Each FIFO is a DEPTH-entry array with `AW`-bit read/write pointers and an (AW+1)-bit occupancy count.
  - Full when count == DEPTH; empty when count == 0.
  - Pointers wrap modulo DEPTH; DEPTH-1 → 0 with no gap.
- Both FIFOs are first-word-fall-through: head data is valid on the data output whenever the corresponding valid is high.
- Status outputs:
  - `cpu_rx_valid` and `host_tx_valid` = (count != 0).
  - `host_rx_ready` and `cpu_tx_ready` = (count != DEPTH).
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged; both pointers advance.
- Push on a full FIFO is impossible: ready is low.
  - A full FIFO does not accept a push in the same cycle as a pop; ready reflects the state at the start of the cycle.
- Pop on an empty FIFO (`cpu_rden` with `cpu_rx_valid`=0): ignored; no state change.
- Write on a full FIFO (`cpu_wren` with `cpu_tx_ready`=0): byte discarded; no state change.
- Byte order is preserved; no byte is duplicated or reordered.

## Timing
- Reset values, asserted on any edge with `reset`=1:
  - Both counts and all pointers = 0.
  - `cpu_rx_valid`=0, `host_tx_valid`=0.
  - `host_rx_ready`=1, `cpu_tx_ready`=1.
  - `cpu_rx_data` and `host_tx_data` = 8'h00.
  - Array contents need not be cleared; data outputs are forced to 0 while empty.
- Reset mid-transfer discards all queued bytes in both FIFOs.
  - A handshake occurring in the reset cycle has no effect.
- Latency, host byte accepted at edge N:
  - `cpu_rx_valid`=1 and `cpu_rx_data` = that byte in the cycle after edge N.
  - The same applies to the TX direction.
- Pop at edge N: the next entry (or empty status) is visible in the cycle after edge N.
- All outputs derive from registered state. There is no combinational path from any input to any output.
- Sustained throughput: one byte per cycle per direction when the producer and consumer are both continuously active.

## Configuration
- Macro: `SERIAL_BRIDGE_STATS_EN`.
- Defined:
  - Adds output `tx_drop_count`, out, 8 bits: increments on each `cpu_wren` while `cpu_tx_ready`=0 and saturates at 8'hFF.
  - Adds output `rx_underrun_count`, out, 8 bits: increments on each `cpu_rden` while `cpu_rx_valid`=0 and saturates at 8'hFF.
  - Both counters reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Reset then idle:
  - `cpu_rx_valid`=0, `host_tx_valid`=0, `host_rx_ready`=1, `cpu_tx_ready`=1, both data outputs 8'h00.
- RX ordering, DEPTH=4:
  - Host pushes 8'hA1, A2, A3, A4 on consecutive cycles, then `host_rx_ready`=0.
  - Core pops four times and reads A1, A2, A3, A4.
  - `cpu_rx_valid`=0 after the fourth pop; a fifth host byte 8'hA5 is then accepted.
- TX full and drop:
  - Core writes 8'h10–13, then 8'h14 while `host_tx_ready`=0.
  - `cpu_tx_ready`=0 after the fourth write.
  - 8'h14 is never emitted; the host later receives 10, 11, 12, 13. With STATS_EN, `tx_drop_count`=1.
- Simultaneous push/pop at occupancy 2:
  - Run for 20 cycles.
  - Count stays 2; output sequence matches input sequence across ≥3 pointer wraps.
- Underrun:
  - `cpu_rden`=1 on an empty RX FIFO for 3 cycles.
  - No state change. With STATS_EN, `rx_underrun_count`=3; after 300 such cycles it reads 8'hFF.
- Reset mid-operation:
  - Both FIFOs hold 3 bytes; assert `reset` for 1 cycle.
  - Both FIFOs are empty in the next cycle, and the old bytes never appear on either output.
